// File: rtl/ps2_kbd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_kbd_pkg
//  Description : Shared constants for the PS/2 keyboard receiver.
//                Contents: register addresses, STATUS bit positions, the
//                receiver state encoding and the hex-to-7-segment glyph
//                function.
//  Revision    : 1.0  initial release
// ============================================================================
package ps2_kbd_pkg;

  // Register map (Avalon word addresses)
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_COUNT   = 2'd3;

  // STATUS register bit positions
  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERFLOW  = 2;
  localparam int STAT_PARITY    = 3;
  localparam int STAT_FRAME     = 4;

  // Receiver frame state
  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  // Active-low segments ordered {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_sseg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_rx_frame
//  Description : PS/2 frame receiver. Synchronises the PS/2 clock and data,
//                glitch-filters the clock, detects falling edges, and
//                assembles start/8 data/odd parity/stop frames. A watchdog
//                abandons a frame whose clock stalls.
//  Ports       : clk, rst        system clock, sync active-high reset
//                i_kc, i_kd      raw asynchronous PS/2 clock / data
//                o_valid/o_data  one-cycle pulse with an accepted byte
//                o_parity_err    one-cycle pulse, parity check failed
//                o_frame_err     one-cycle pulse, bad stop bit or timeout
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_rx_frame
  import ps2_kbd_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_kc,
  input  logic       i_kd,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_parity_err,
  output logic       o_frame_err
);

  localparam int FW   = $clog2(FILTER_LEN + 1);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic            kc_meta_q, kc_sync_q, kd_meta_q, kd_sync_q;
  logic            filt_q, filt_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic            fall_q, fall_d;
  rx_state_e       state_q, state_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            valid_q, valid_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;

  // Filter: the level only follows the synchronised clock after it has
  // disagreed for FILTER_LEN consecutive samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (kc_sync_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = kc_sync_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
    fall_d = filt_q & ~filt_d;
  end

  // Frame FSM and watchdog
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;

    if (state_q == RX_IDLE || fall_q) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + 1'b1;
    end

    case (state_q)
      RX_IDLE: begin
        if (fall_q && !kd_sync_q) begin
          state_d   = RX_DATA;
          bit_idx_d = 3'd0;
        end
      end
      RX_DATA: begin
        if (fall_q) begin
          shift_d   = {kd_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (fall_q) begin
          parity_d = kd_sync_q;
          state_d  = RX_STOP;
        end
      end
      default: begin
        if (fall_q) begin
          perr_d  = ~(^{shift_q, parity_q});
          ferr_d  = ~kd_sync_q;
          valid_d = (^{shift_q, parity_q}) & kd_sync_q;
          state_d = RX_IDLE;
        end
      end
    endcase

    // A stalled clock inside a frame abandons the partial byte
    if (state_q != RX_IDLE && !fall_q && wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
      state_d = RX_IDLE;
      ferr_d  = 1'b1;
      valid_d = 1'b0;
      perr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kc_meta_q <= 1'b1;
      kc_sync_q <= 1'b1;
      kd_meta_q <= 1'b1;
      kd_sync_q <= 1'b1;
      filt_q    <= 1'b1;
      fcnt_q    <= '0;
      fall_q    <= 1'b0;
      state_q   <= RX_IDLE;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      parity_q  <= 1'b0;
      wd_q      <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      kc_meta_q <= i_kc;
      kc_sync_q <= kc_meta_q;
      kd_meta_q <= i_kd;
      kd_sync_q <= kd_meta_q;
      filt_q    <= filt_d;
      fcnt_q    <= fcnt_d;
      fall_q    <= fall_d;
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      wd_q      <= wd_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign o_valid      = valid_q;
  assign o_data       = shift_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_keyboard_fifo
//  Description : PS/2 keyboard receiver with Avalon-MM slave, scancode FIFO,
//                level IRQ and 7-segment history of recent scancodes.
//  Ports       : csi_clk, csi_reset          clock, sync active-high reset
//                avs_s1_*                     register slave, 1-cycle read
//                ins_irq0_irq                 registered irq_en & not_empty
//                coe_kc, coe_kd               raw PS/2 clock / data
//                coe_sseg                     active-low segments, 7 per digit
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_keyboard_fifo
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int NUM_DIGITS     = 2
) (
  input  logic                    csi_clk,
  input  logic                    csi_reset,
  input  logic [1:0]              avs_s1_address,
  input  logic                    avs_s1_read,
  output logic [7:0]              avs_s1_readdata,
  input  logic                    avs_s1_write,
  input  logic [7:0]              avs_s1_writedata,
  output logic                    ins_irq0_irq,
  input  logic                    coe_kc,
  input  logic                    coe_kd,
  output logic [7*NUM_DIGITS-1:0] coe_sseg
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int HIST_W = 4 * NUM_DIGITS;

  logic       rx_valid, rx_perr, rx_ferr;
  logic [7:0] rx_data;

  ps2_rx_frame #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk          (csi_clk),
    .rst          (csi_reset),
    .i_kc         (coe_kc),
    .i_kd         (coe_kd),
    .o_valid      (rx_valid),
    .o_data       (rx_data),
    .o_parity_err (rx_perr),
    .o_frame_err  (rx_ferr)
  );

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2:0]        sticky_q, sticky_d;   // {frame, parity, overflow}
  logic              irq_en_q, irq_en_d;
  logic              irq_q, irq_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [HIST_W-1:0] hist_q, hist_d;

  logic not_empty, full, pop, push_ok, ovf_set;
  logic wr_status, wr_control;
  logic [7:0] status_byte;
  logic unused_wdata;

  assign not_empty   = (count_q != '0);
  assign full        = (count_q == CW'(FIFO_DEPTH));
  assign pop         = avs_s1_read && (avs_s1_address == ADDR_DATA) && not_empty;
  // A pop in the same cycle frees a slot even when full
  assign push_ok     = rx_valid && (!full || pop);
  assign ovf_set     = rx_valid && full && !pop;
  assign wr_status   = avs_s1_write && (avs_s1_address == ADDR_STATUS);
  assign wr_control  = avs_s1_write && (avs_s1_address == ADDR_CONTROL);
  assign status_byte = {3'b000, sticky_q, full, not_empty};
  assign unused_wdata = ^{avs_s1_writedata[7:5], avs_s1_writedata[1]};

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push_ok) - CW'(pop);

    // Clear first, then set: a fresh error wins over a simultaneous W1C
    sticky_d = sticky_q;
    if (wr_status) sticky_d = sticky_d & ~avs_s1_writedata[4:2];
    sticky_d = sticky_d | {rx_ferr, rx_perr, ovf_set};

    irq_en_d = wr_control ? avs_s1_writedata[0] : irq_en_q;
    irq_d    = irq_en_q & not_empty;

    rdata_d = rdata_q;
    if (avs_s1_read) begin
      case (avs_s1_address)
        ADDR_DATA:    rdata_d = not_empty ? mem_q[rd_ptr_q] : 8'h00;
        ADDR_STATUS:  rdata_d = status_byte;
        ADDR_CONTROL: rdata_d = {7'b0, irq_en_q};
        default:      rdata_d = 8'(count_q);
      endcase
    end

    // Display tracks every accepted byte, including ones lost to overflow
    hist_d = hist_q;
    if (rx_valid) hist_d = (hist_q << 8) | HIST_W'(rx_data);
  end

  always_ff @(posedge csi_clk) begin
    if (csi_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sticky_q <= 3'b000;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      rdata_q  <= 8'h00;
      hist_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
      hist_q   <= hist_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid
  always_ff @(posedge csi_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= rx_data;
  end

  assign avs_s1_readdata = rdata_q;
  assign ins_irq0_irq    = irq_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign coe_sseg[7*gi +: 7] = hex_to_sseg(hist_q[4*gi +: 4]);
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_keyboard_fifo
//  Description : Directed self-checking bench for ps2_keyboard_fifo.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_keyboard_fifo;

  localparam int DEPTH   = 4;
  localparam int FLEN    = 4;
  localparam int TMO     = 500;
  localparam int DIGITS  = 4;
  localparam int HALF    = 100;   // PS/2 half period in system clocks

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic        rd = 1'b0;
  logic [7:0]  rdata;
  logic        wr = 1'b0;
  logic [7:0]  wdata = 8'h00;
  logic        irq;
  logic        kc = 1'b1;
  logic        kd = 1'b1;
  logic [7*DIGITS-1:0] sseg;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ps2_keyboard_fifo #(
    .FIFO_DEPTH     (DEPTH),
    .FILTER_LEN     (FLEN),
    .TIMEOUT_CYCLES (TMO),
    .NUM_DIGITS     (DIGITS)
  ) dut (
    .csi_clk          (clk),
    .csi_reset        (rst),
    .avs_s1_address   (addr),
    .avs_s1_read      (rd),
    .avs_s1_readdata  (rdata),
    .avs_s1_write     (wr),
    .avs_s1_writedata (wdata),
    .ins_irq0_irq     (irq),
    .coe_kc           (kc),
    .coe_kd           (kd),
    .coe_sseg         (sseg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    addr = a; rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
    d = rdata;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    addr = a; wdata = d; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  // Clock out the first n bits (bit 0 first). glitch_bit selects a bit
  // whose high phase carries a 2-cycle low pulse, shorter than the filter.
  task automatic send_bits(input logic [10:0] bits, input int n, input int glitch_bit);
    for (int i = 0; i < n; i++) begin
      kd = bits[i];
      if (i == glitch_bit) begin
        repeat (40) @(posedge clk);
        kc = 1'b0;
        repeat (2) @(posedge clk);
        kc = 1'b1;
        repeat (HALF - 42) @(posedge clk);
      end else begin
        repeat (HALF) @(posedge clk);
      end
      kc = 1'b0;
      repeat (HALF) @(posedge clk);
      kc = 1'b1;
    end
    kd = 1'b1;
    repeat (HALF) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                            input int glitch_bit);
    send_bits({stp, par, b, 1'b0}, 11, glitch_bit);
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    return ~(^b);
  endfunction

  logic [7:0] d;

  initial begin
    // ---------------- reset state
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_readdata", rdata, 8'h00);
    check("rst_irq", irq, 1'b0);
    check("rst_sseg", sseg, {4{7'h40}});
    reg_read(2'd1, d); check("rst_status", d, 8'h00);
    reg_read(2'd3, d); check("rst_count", d, 8'h00);
    reg_read(2'd2, d); check("rst_control", d, 8'h00);

    // ---------------- single good frame 0x1C
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    reg_read(2'd3, d); check("f1c_count", d, 8'd1);
    reg_read(2'd1, d); check("f1c_status", d, 8'h01);
    check("f1c_sseg", sseg, {7'h40, 7'h40, 7'h79, 7'h46});
    reg_read(2'd0, d); check("f1c_data", d, 8'h1C);
    reg_read(2'd3, d); check("f1c_count0", d, 8'd0);
    reg_read(2'd0, d); check("empty_data", d, 8'h00);

    // ---------------- parity error
    send_frame(8'hF0, 1'b0, 1'b1, -1);
    reg_read(2'd1, d); check("perr_status", d, 8'h08);
    reg_read(2'd3, d); check("perr_count", d, 8'd0);
    check("perr_sseg", sseg, {7'h40, 7'h40, 7'h79, 7'h46});
    reg_write(2'd1, 8'h08);
    reg_read(2'd1, d); check("perr_clr", d, 8'h00);

    // ---------------- bad stop bit
    send_frame(8'h33, odd_par(8'h33), 1'b0, -1);
    reg_read(2'd1, d); check("ferr_status", d, 8'h10);
    reg_write(2'd1, 8'h10);
    reg_read(2'd1, d); check("ferr_clr", d, 8'h00);

    // ---------------- IRQ with three frames
    reg_write(2'd2, 8'hFF);
    reg_read(2'd2, d); check("ctrl_rd", d, 8'h01);
    check("irq_idle", irq, 1'b0);
    send_frame(8'hE0, odd_par(8'hE0), 1'b1, -1);
    check("irq_first", irq, 1'b1);
    send_frame(8'hF0, odd_par(8'hF0), 1'b1, -1);
    send_frame(8'h1C, odd_par(8'h1C), 1'b1, -1);
    reg_read(2'd3, d); check("irq_count3", d, 8'd3);
    check("hist_sseg", sseg, {7'h0E, 7'h40, 7'h79, 7'h46});
    reg_read(2'd0, d); check("irq_d0", d, 8'hE0);
    reg_read(2'd0, d); check("irq_d1", d, 8'hF0);
    reg_read(2'd0, d); check("irq_d2", d, 8'h1C);
    check("irq_hold", irq, 1'b1);
    @(posedge clk); #1;
    check("irq_drop", irq, 1'b0);
    reg_write(2'd2, 8'h00);

    // ---------------- overflow: DEPTH+1 frames
    send_frame(8'h11, odd_par(8'h11), 1'b1, -1);
    send_frame(8'h22, odd_par(8'h22), 1'b1, -1);
    send_frame(8'h33, odd_par(8'h33), 1'b1, -1);
    send_frame(8'h44, odd_par(8'h44), 1'b1, -1);
    send_frame(8'h55, odd_par(8'h55), 1'b1, -1);
    reg_read(2'd3, d); check("ovf_count", d, 8'd4);
    reg_read(2'd1, d); check("ovf_status", d, 8'h07);
    check("ovf_sseg", sseg, {7'h19, 7'h19, 7'h12, 7'h12});
    reg_read(2'd0, d); check("ovf_d0", d, 8'h11);
    reg_read(2'd0, d); check("ovf_d1", d, 8'h22);
    reg_read(2'd0, d); check("ovf_d2", d, 8'h33);
    reg_read(2'd0, d); check("ovf_d3", d, 8'h44);
    reg_write(2'd1, 8'h04);
    reg_read(2'd1, d); check("ovf_clr", d, 8'h00);

    // ---------------- timeout after start + 4 data bits
    send_bits(11'b000_0000_1010, 5, -1);
    repeat (TMO + 50) @(posedge clk);
    reg_read(2'd1, d); check("tmo_status", d, 8'h10);
    reg_write(2'd1, 8'h10);
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    reg_read(2'd1, d); check("tmo_next_status", d, 8'h01);
    reg_read(2'd0, d); check("tmo_next_data", d, 8'h1C);

    // ---------------- short glitches in IDLE and DATA
    kc = 1'b0;
    repeat (2) @(posedge clk);
    kc = 1'b1;
    repeat (HALF) @(posedge clk);
    send_frame(8'hA5, odd_par(8'hA5), 1'b1, 4);
    reg_read(2'd3, d); check("glitch_count", d, 8'd1);
    reg_read(2'd1, d); check("glitch_status", d, 8'h01);
    reg_read(2'd0, d); check("glitch_data", d, 8'hA5);

    // ---------------- reset in the middle of a frame
    send_frame(8'h22, odd_par(8'h22), 1'b1, -1);
    send_bits(11'b000_0000_0110, 3, -1);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    reg_read(2'd3, d); check("mrst_count", d, 8'd0);
    reg_read(2'd1, d); check("mrst_status", d, 8'h00);
    check("mrst_sseg", sseg, {4{7'h40}});
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    reg_read(2'd0, d); check("mrst_data", d, 8'h1C);
    reg_read(2'd1, d); check("mrst_status2", d, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
